// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: frame-level VGA timing generator.
// A clock divider produces the pixel tick; a horizontal and a vertical
// segment FSM (ACT/FP/SYNC/BP) each track their own counter. Frames always
// complete once started; en_i is only honoured at frame boundaries.
module vga_timing_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  output logic       tick_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       de_o,
  output logic [9:0] x_o,
  output logic [9:0] y_o,
  output logic       line_o,
  output logic       frame_o,
  output logic       busy_o
);

  // Both totals must fit the 10-bit counters (<= 1024).
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic {ST_IDLE, ST_RUN} run_e;
  typedef enum logic [1:0] {HS_ACT, HS_FP, HS_SYNC, HS_BP} h_seg_e;
  typedef enum logic [1:0] {VS_ACT, VS_FP, VS_SYNC, VS_BP} v_seg_e;

  run_e             st;
  h_seg_e           h_st, h_st_nx;
  v_seg_e           v_st, v_st_nx;
  logic [DIV_W-1:0] div;
  logic [9:0]       hcnt, vcnt, h_nx, v_nx;
  logic             first;
  logic             tick, eol, eof;

  function automatic int h_len(input h_seg_e s);
    case (s)
      HS_ACT:  return H_ACTIVE;
      HS_FP:   return H_FP;
      HS_SYNC: return H_SYNC;
      default: return H_BP;
    endcase
  endfunction

  function automatic int v_len(input v_seg_e s);
    case (s)
      VS_ACT:  return V_ACTIVE;
      VS_FP:   return V_FP;
      VS_SYNC: return V_SYNC;
      default: return V_BP;
    endcase
  endfunction

  // Next non-empty segment after s; zero-length segments are skipped.
  function automatic h_seg_e h_after(input h_seg_e s);
    h_seg_e n;
    logic   done;
    n    = s;
    done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!done) begin
        case (n)
          HS_ACT:  n = HS_FP;
          HS_FP:   n = HS_SYNC;
          HS_SYNC: n = HS_BP;
          default: n = HS_ACT;
        endcase
        done = (h_len(n) != 0);
      end
    end
    return n;
  endfunction

  function automatic v_seg_e v_after(input v_seg_e s);
    v_seg_e n;
    logic   done;
    n    = s;
    done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!done) begin
        case (n)
          VS_ACT:  n = VS_FP;
          VS_FP:   n = VS_SYNC;
          VS_SYNC: n = VS_BP;
          default: n = VS_ACT;
        endcase
        done = (v_len(n) != 0);
      end
    end
    return n;
  endfunction

  // Last count value belonging to each segment.
  function automatic logic [9:0] h_end(input h_seg_e s);
    case (s)
      HS_ACT:  return 10'(H_ACTIVE - 1);
      HS_FP:   return 10'(H_ACTIVE + H_FP - 1);
      HS_SYNC: return 10'(H_ACTIVE + H_FP + H_SYNC - 1);
      default: return 10'(H_TOTAL - 1);
    endcase
  endfunction

  function automatic logic [9:0] v_end(input v_seg_e s);
    case (s)
      VS_ACT:  return 10'(V_ACTIVE - 1);
      VS_FP:   return 10'(V_ACTIVE + V_FP - 1);
      VS_SYNC: return 10'(V_ACTIVE + V_FP + V_SYNC - 1);
      default: return 10'(V_TOTAL - 1);
    endcase
  endfunction

  assign x_o    = hcnt;
  assign y_o    = vcnt;
  assign busy_o = (st == ST_RUN);

  // Next pixel position and segment states; the first tick of a run
  // presents (0,0) without advancing.
  always_comb begin
    tick    = (st == ST_RUN) && (div == DIV_W'(CLK_DIV - 1));
    eol     = (hcnt == 10'(H_TOTAL - 1));
    eof     = eol && (vcnt == 10'(V_TOTAL - 1));
    h_nx    = hcnt;
    v_nx    = vcnt;
    h_st_nx = h_st;
    v_st_nx = v_st;
    if (!first) begin
      h_nx = eol ? 10'd0 : hcnt + 10'd1;
      if (hcnt == h_end(h_st)) h_st_nx = h_after(h_st);
      if (eol) begin
        v_nx = eof ? 10'd0 : vcnt + 10'd1;
        if (vcnt == v_end(v_st)) v_st_nx = v_after(v_st);
      end
    end
  end

  // Run FSM, divider, counters and registered timing outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st      <= ST_IDLE;
      div     <= '0;
      first   <= 1'b1;
      hcnt    <= '0;
      vcnt    <= '0;
      h_st    <= h_after(HS_BP);
      v_st    <= v_after(VS_BP);
      tick_o  <= 1'b0;
      hsync_o <= 1'b1;
      vsync_o <= 1'b1;
      de_o    <= 1'b0;
      line_o  <= 1'b0;
      frame_o <= 1'b0;
    end else if (st == ST_IDLE) begin
      div   <= '0;
      first <= 1'b1;
      if (en_i) st <= ST_RUN;
    end else begin
      div     <= tick ? '0 : div + DIV_W'(1);
      tick_o  <= 1'b0;
      line_o  <= 1'b0;
      frame_o <= 1'b0;
      if (tick) begin
        if (eof && !first && !en_i) begin
          // Frame finished with no run request: park in IDLE.
          st      <= ST_IDLE;
          first   <= 1'b1;
          hcnt    <= '0;
          vcnt    <= '0;
          h_st    <= h_after(HS_BP);
          v_st    <= v_after(VS_BP);
          hsync_o <= 1'b1;
          vsync_o <= 1'b1;
          de_o    <= 1'b0;
        end else begin
          first   <= 1'b0;
          tick_o  <= 1'b1;
          hcnt    <= h_nx;
          vcnt    <= v_nx;
          h_st    <= h_st_nx;
          v_st    <= v_st_nx;
          hsync_o <= (h_st_nx != HS_SYNC);
          vsync_o <= (v_st_nx != VS_SYNC);
          de_o    <= (h_st_nx == HS_ACT) && (v_st_nx == VS_ACT);
          line_o  <= (h_nx == 10'd0);
          frame_o <= (h_nx == 10'd0) && (v_nx == 10'd0);
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: scoreboard bench for vga_timing_ctrl.
// Three instances: small raster with CLK_DIV=1 (a) and CLK_DIV=3 (b), and
// the default 640x480 raster with CLK_DIV=2 (c).
module tb_vga_timing_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Reference pixel for the n-th tick of a continuous run.
  // Packing: {x[9:0], y[9:0], hsync, vsync, de, line, frame}
  function automatic logic [24:0] model_pix(input int n, input int ha, input int hf, input int hs,
                                            input int hb, input int va, input int vf, input int vs,
                                            input int vb);
    int   ht, vt, x, y;
    logic hsy, vsy, de;
    ht  = ha + hf + hs + hb;
    vt  = va + vf + vs + vb;
    x   = n % ht;
    y   = (n / ht) % vt;
    hsy = !(x >= ha + hf && x < ha + hf + hs);
    vsy = !(y >= va + vf && y < va + vf + vs);
    de  = (x < ha) && (y < va);
    return {x[9:0], y[9:0], hsy, vsy, de, (x == 0), (x == 0 && y == 0)};
  endfunction

  logic       rst_a, en_a, a_tick, a_hs, a_vs, a_de, a_line, a_frame, a_busy;
  logic [9:0] a_x, a_y;
  logic       rst_b, en_b, b_tick, b_hs, b_vs, b_de, b_line, b_frame, b_busy;
  logic [9:0] b_x, b_y;
  logic       rst_c, en_c, c_tick, c_hs, c_vs, c_de, c_line, c_frame, c_busy;
  logic [9:0] c_x, c_y;

  vga_timing_ctrl #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .CLK_DIV(1)) u_a (
    .clk_i(clk), .rst_i(rst_a), .en_i(en_a), .tick_o(a_tick), .hsync_o(a_hs), .vsync_o(a_vs),
    .de_o(a_de), .x_o(a_x), .y_o(a_y), .line_o(a_line), .frame_o(a_frame), .busy_o(a_busy));

  vga_timing_ctrl #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .CLK_DIV(3)) u_b (
    .clk_i(clk), .rst_i(rst_b), .en_i(en_b), .tick_o(b_tick), .hsync_o(b_hs), .vsync_o(b_vs),
    .de_o(b_de), .x_o(b_x), .y_o(b_y), .line_o(b_line), .frame_o(b_frame), .busy_o(b_busy));

  vga_timing_ctrl #(.CLK_DIV(2)) u_c (
    .clk_i(clk), .rst_i(rst_c), .en_i(en_c), .tick_o(c_tick), .hsync_o(c_hs), .vsync_o(c_vs),
    .de_o(c_de), .x_o(c_x), .y_o(c_y), .line_o(c_line), .frame_o(c_frame), .busy_o(c_busy));

  logic [24:0] a_q[$];
  logic [24:0] b_q[$];
  logic [24:0] c_q[$];

  // Monitor a: pixel scoreboard plus tick, line and frame spacing.
  int a_lt = -1, a_ll = -1, a_lf = -1;
  always @(negedge clk) begin
    if (a_tick) begin
      check_eq("a_tick_expected", 64'(a_q.size() > 0), 64'd1);
      if (a_q.size() > 0)
        check_eq("a_pixel", 64'({a_x, a_y, a_hs, a_vs, a_de, a_line, a_frame}), 64'(a_q.pop_front()));
      if (a_lt >= 0) check_eq("a_tick_gap", 64'(cyc - a_lt), 64'd1);
      a_lt = cyc;
      if (a_line) begin
        if (a_ll >= 0) check_eq("a_line_period", 64'(cyc - a_ll), 64'd8);
        a_ll = cyc;
      end
      if (a_frame) begin
        if (a_lf >= 0) check_eq("a_frame_period", 64'(cyc - a_lf), 64'd48);
        a_lf = cyc;
      end
    end
    if (!a_busy) begin a_lt = -1; a_ll = -1; a_lf = -1; end
  end

  // Monitor b: as a, plus outputs must hold steady between ticks.
  int          b_lt = -1, b_ll = -1, b_lf = -1;
  logic [24:0] b_prev;
  bit          b_seen = 1'b0;
  always @(negedge clk) begin
    if (b_tick) begin
      check_eq("b_tick_expected", 64'(b_q.size() > 0), 64'd1);
      if (b_q.size() > 0)
        check_eq("b_pixel", 64'({b_x, b_y, b_hs, b_vs, b_de, b_line, b_frame}), 64'(b_q.pop_front()));
      if (b_lt >= 0) check_eq("b_tick_gap", 64'(cyc - b_lt), 64'd3);
      b_lt = cyc;
      if (b_line) begin
        if (b_ll >= 0) check_eq("b_line_period", 64'(cyc - b_ll), 64'd24);
        b_ll = cyc;
      end
      if (b_frame) begin
        if (b_lf >= 0) check_eq("b_frame_period", 64'(cyc - b_lf), 64'd144);
        b_lf = cyc;
      end
      b_prev = {b_x, b_y, b_hs, b_vs, b_de, b_line, b_frame};
      b_seen = 1'b1;
    end else if (b_busy && b_seen) begin
      check_eq("b_hold", 64'({b_x, b_y, b_hs, b_vs, b_de, b_line, b_frame}), 64'({b_prev[24:2], 2'b00}));
    end
    if (!b_busy) begin b_lt = -1; b_ll = -1; b_lf = -1; b_seen = 1'b0; end
  end

  // Monitor c: scoreboard, line period and hsync placement/width.
  int   c_lt = -1, c_ll = -1, c_hf = -1, c_hs_cnt = 0;
  logic c_hs_prev = 1'b1;
  always @(negedge clk) begin
    if (c_tick) begin
      check_eq("c_tick_expected", 64'(c_q.size() > 0), 64'd1);
      if (c_q.size() > 0)
        check_eq("c_pixel", 64'({c_x, c_y, c_hs, c_vs, c_de, c_line, c_frame}), 64'(c_q.pop_front()));
      if (c_lt >= 0) check_eq("c_tick_gap", 64'(cyc - c_lt), 64'd2);
      c_lt = cyc;
      if (c_line) begin
        if (c_ll >= 0) check_eq("c_line_period", 64'(cyc - c_ll), 64'd1600);
        c_ll = cyc;
      end
    end
    if (c_hs_prev && !c_hs) begin
      check_eq("c_hsync_start_x", 64'(c_x), 64'd656);
      c_hf = cyc;
    end
    if (!c_hs_prev && c_hs && c_hf >= 0) begin
      check_eq("c_hsync_width", 64'(cyc - c_hf), 64'd192);
      c_hs_cnt++;
      c_hf = -1;
    end
    c_hs_prev = c_hs;
    if (!c_busy) begin c_lt = -1; c_ll = -1; end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int k;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("a_rst_hsync", 64'(a_hs), 64'd1);
    check_eq("a_rst_vsync", 64'(a_vs), 64'd1);
    check_eq("a_rst_xy", 64'({a_x, a_y}), 64'd0);
    check_eq("a_rst_flags", 64'({a_de, a_tick, a_line, a_frame, a_busy}), 64'd0);
    check_eq("c_rst_state", 64'({c_hs, c_vs, c_de, c_busy, c_x, c_y}), 64'({1'b1, 1'b1, 22'd0}));
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("a_idle_wait_en", 64'({a_busy, a_tick}), 64'd0);

    // a: two frames, en dropped at (2,1) of the second frame.
    for (int n = 0; n < 96; n++) a_q.push_back(model_pix(n, 4, 1, 2, 1, 3, 1, 1, 1));
    en_a = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!a_frame && k < 20);
    check_eq("a_start_latency", 64'(k), 64'd2);
    k = 0;
    do begin @(negedge clk); k++; end while (!a_frame && k < 100);
    check_eq("a_second_frame", 64'(k), 64'd48);
    k = 0;
    while (!(a_x == 2 && a_y == 1) && k < 100) begin @(negedge clk); k++; end
    en_a = 1'b0;
    k = 0;
    while (a_busy && k < 200) begin @(negedge clk); k++; end
    check_eq("a_drop_busy_falls", 64'(a_busy), 64'd0);
    check_eq("a_drop_queue_drained", 64'(a_q.size()), 64'd0);
    check_eq("a_drop_idle_outputs", 64'({a_hs, a_vs, a_de, a_x, a_y}), 64'({1'b1, 1'b1, 21'd0}));

    // a: single-cycle en pulse runs exactly one frame.
    for (int n = 0; n < 48; n++) a_q.push_back(model_pix(n, 4, 1, 2, 1, 3, 1, 1, 1));
    en_a = 1'b1;
    @(negedge clk);
    en_a = 1'b0;
    k = 0;
    while (a_busy && k < 200) begin @(negedge clk); k++; end
    check_eq("a_pulse_busy_falls", 64'(a_busy), 64'd0);
    check_eq("a_pulse_queue_drained", 64'(a_q.size()), 64'd0);
    check_eq("a_pulse_idle_outputs", 64'({a_hs, a_vs, a_x, a_y}), 64'({1'b1, 1'b1, 20'd0}));
    repeat (10) @(negedge clk);
    check_eq("a_pulse_stays_idle", 64'(a_busy), 64'd0);

    // a: restart, then asynchronous reset inside the sync corner (5,4).
    for (int n = 0; n < 48; n++) a_q.push_back(model_pix(n, 4, 1, 2, 1, 3, 1, 1, 1));
    en_a = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!a_frame && k < 20);
    check_eq("a_restart_latency", 64'(k), 64'd2);
    k = 0;
    while (!(a_x == 5 && a_y == 4) && k < 100) begin @(negedge clk); k++; end
    check_eq("a_sync_corner", 64'({a_hs, a_vs}), 64'd0);
    #1 rst_a = 1'b1;
    #1;
    check_eq("a_async_rst_syncs", 64'({a_hs, a_vs}), 64'd3);
    check_eq("a_async_rst_flags", 64'({a_de, a_busy, a_tick}), 64'd0);
    check_eq("a_async_rst_xy", 64'({a_x, a_y}), 64'd0);
    a_q.delete();
    en_a = 1'b0;
    @(negedge clk);
    rst_a = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("a_post_rst_idle", 64'(a_busy), 64'd0);

    // b: CLK_DIV=3, two frames.
    for (int n = 0; n < 96; n++) b_q.push_back(model_pix(n, 4, 1, 2, 1, 3, 1, 1, 1));
    en_b = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!b_frame && k < 40);
    check_eq("b_start_latency", 64'(k), 64'd4);
    k = 0;
    do begin @(negedge clk); k++; end while (!b_frame && k < 300);
    check_eq("b_second_frame", 64'(k), 64'd144);
    en_b = 1'b0;
    k = 0;
    while (b_busy && k < 600) begin @(negedge clk); k++; end
    check_eq("b_busy_falls", 64'(b_busy), 64'd0);
    check_eq("b_queue_drained", 64'(b_q.size()), 64'd0);

    // c: default raster, first three lines.
    for (int n = 0; n < 2400; n++) c_q.push_back(model_pix(n, 640, 16, 96, 48, 480, 10, 2, 33));
    en_c = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!c_frame && k < 40);
    check_eq("c_start_latency", 64'(k), 64'd3);
    k = 0;
    while (c_q.size() != 0 && k < 6000) begin @(negedge clk); #1; k++; end
    check_eq("c_queue_drained", 64'(c_q.size()), 64'd0);
    rst_c = 1'b1;
    en_c  = 1'b0;
    #1;
    check_eq("c_async_rst", 64'({c_busy, c_x, c_y}), 64'd0);
    check_eq("c_hsync_pulses", 64'(c_hs_cnt), 64'd3);
    @(negedge clk);
    rst_c = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
